// File: rtl/button_event_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | button_event_pkg : shared types and sizing helper for button_event_gen |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package button_event_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PRESSED = 2'd1,
      S_LONG    = 2'd2
   } state_t;

   // Sized so the larger terminal count fits with one bit of headroom.
   function automatic int counter_width(input int long_ticks, input int repeat_ticks);
      int m;
      m = (long_ticks > repeat_ticks) ? long_ticks : repeat_ticks;
      return $clog2(m) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/button_event_gen_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | event_timer : clear/enable up-counter with terminal-count compare     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module event_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] limit,
   output logic             tc
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (enable) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign tc = (r_count == limit);

endmodule

`default_nettype wire

// File: rtl/button_event_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | button_event_gen : press/release/tap/long-press event pulses from a   |
// | debounced level; optional auto-repeat via BUTTON_AUTOREPEAT_EN.       |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module button_event_gen
   import button_event_pkg::*;
#(
   parameter int LONG_TICKS   = 50_000_000,
   parameter int REPEAT_TICKS = 10_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic debounced_in,
   output logic held,
   output logic press,
   output logic release_pulse,
   output logic tap,
   output logic long_press,
   output logic repeat_pulse
);

   localparam int c_CNT_W = counter_width(LONG_TICKS, REPEAT_TICKS);
   localparam logic [c_CNT_W-1:0] c_LONG_TC   = c_CNT_W'(LONG_TICKS - 1);
   localparam logic [c_CNT_W-1:0] c_REPEAT_TC = c_CNT_W'(REPEAT_TICKS - 1);

   state_t r_state, w_state_next;
   logic   r_held, r_press, r_release, r_tap, r_long;
   logic   w_press_next, w_release_next, w_tap_next, w_long_next;
   logic   w_clear, w_enable, w_tc;
   logic [c_CNT_W-1:0] w_limit;
`ifdef BUTTON_AUTOREPEAT_EN
   logic   r_repeat, w_repeat_next;
`endif

   assign w_limit = (r_state == S_LONG) ? c_REPEAT_TC : c_LONG_TC;

   event_timer #(.WIDTH(c_CNT_W)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (w_clear),
      .enable (w_enable),
      .limit  (w_limit),
      .tc     (w_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_held    <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_tap     <= 1'b0;
         r_long    <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_held    <= (w_state_next != S_IDLE);
         r_press   <= w_press_next;
         r_release <= w_release_next;
         r_tap     <= w_tap_next;
         r_long    <= w_long_next;
      end
   end

   // A release always takes priority over a terminal count on the same edge.
   always_comb begin
      w_state_next   = r_state;
      w_clear        = 1'b0;
      w_enable       = 1'b0;
      w_press_next   = 1'b0;
      w_release_next = 1'b0;
      w_tap_next     = 1'b0;
      w_long_next    = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      w_repeat_next  = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (debounced_in) begin
               w_state_next = S_PRESSED;
               w_clear      = 1'b1;
               w_press_next = 1'b1;
            end
         end
         S_PRESSED: begin
            if (!debounced_in) begin
               w_state_next   = S_IDLE;
               w_clear        = 1'b1;
               w_release_next = 1'b1;
               w_tap_next     = 1'b1;
            end else if (w_tc) begin
               w_state_next = S_LONG;
               w_clear      = 1'b1;
               w_long_next  = 1'b1;
            end else begin
               w_enable = 1'b1;
            end
         end
         S_LONG: begin
            if (!debounced_in) begin
               w_state_next   = S_IDLE;
               w_clear        = 1'b1;
               w_release_next = 1'b1;
            end else begin
`ifdef BUTTON_AUTOREPEAT_EN
               if (w_tc) begin
                  w_clear       = 1'b1;
                  w_repeat_next = 1'b1;
               end else begin
                  w_enable = 1'b1;
               end
`endif
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_clear      = 1'b1;
         end
      endcase
   end

`ifdef BUTTON_AUTOREPEAT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_repeat <= 1'b0;
      end else begin
         r_repeat <= w_repeat_next;
      end
   end
   assign repeat_pulse = r_repeat;
`else
   assign repeat_pulse = 1'b0;
`endif

   assign held          = r_held;
   assign press         = r_press;
   assign release_pulse = r_release;
   assign tap           = r_tap;
   assign long_press    = r_long;

endmodule

`default_nettype wire
